aes256_enc_sequencer: RTL
=========================

# aes256_enc_sequencer

Iterative AES-256 encryption controller that sequences a single shared 128-bit `subbytes` instance across all 14 rounds and the on-the-fly key expansion. Each round key from 2 to 14 takes a key phase, which runs the SubWord operand through lane 0 of `subbytes`, and then a data phase, which runs the full state through `subbytes`. The block sits between the host-side load/start interface and the combinational round datapath: ShiftRows, MixColumns and AddRoundKey.

## Interface
Parameters:
- none. Key size is fixed at 256 bits and round count at 14.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only while idle.
- `key`  in  256  cipher key, FIPS-197 byte order; `key[255:248]` = byte 0. Sampled with `start`.
- `plaintext`  in  128  input block; `[127:120]` = state byte 0, column-major. Sampled with `start`.
- `busy`  out  1  high from the edge that samples `start` until `done` rises.
- `done`  out  1  one-cycle pulse; `ciphertext` is valid from this cycle.
- `ciphertext`  out  128  result, held until the next accepted `start` or `rst`.

## Operation
- FSM states: IDLE, KEY, DATA, FIN.
- Round counter `rnd`: 4 bits, range 1..14.
- Round-key window: `rk_prev` = rk(r-2) and `rk_cur` = rk(r-1), 128 bits each.
- **IDLE, `start`=1:**
  - `state <= plaintext ^ key[255:128]`
  - `rk_prev <= key[255:128]`, `rk_cur <= key[127:0]`
  - `rnd <= 1`, go to DATA. Round 1 uses `key[127:0]` directly and has no key phase.
- **KEY (rnd 2..14), subbytes input = {operand, 96'h0}:**
  - Operand is `RotWord(rk_cur.w3)` when `rnd` is even, else `rk_cur.w3`.
  - temp = `sb[127:96] ^ {RCON[rnd/2], 24'h0}` when `rnd` is even, else `sb[127:96]`.
  - New words: w0 = `rk_prev.w0 ^ temp`, wi = `rk_prev.wi ^ w(i-1)`.
  - Update `rk_prev <= rk_cur`, `rk_cur <= new`. Go to DATA.
- **DATA, subbytes input = state:**
  - `state <= MixColumns(ShiftRows(sb)) ^ rk_cur` when `rnd` < 14.
  - When `rnd` = 14, MixColumns is skipped.
  - If `rnd` = 14: load `ciphertext`, go to FIN. Otherwise `rnd++` and go to KEY.
  - Round 1 reads `rk_cur` = `key[127:0]`.
- **FIN:** `done`=1 for exactly one cycle, then IDLE.
- Mux select of `subbytes` input is a pure function of FSM state. KEY and DATA are never active in the same cycle.
- `start` while `busy`: ignored, with no effect on any register. `start` in the FIN cycle: ignored.
- Mid-operation `rst`: aborts immediately with no partial output.

## Timing
- Reset values: `busy`=0, `done`=0, `ciphertext`=0, state=IDLE, `rnd`=0, all internal registers 0.
- Schedule, counting the `start`-sampling edge as E0:
  - Round 1 DATA completes at E1.
  - Round r ≥ 2 has KEY at E(2r-2) and DATA at E(2r-1).
  - Round 14 DATA completes at E27.
- `done`=1 and `ciphertext` valid in the cycle after E27, which is 27 edges after E0.
- `busy`=1 during cycles E0+ through E27, and 0 in the `done` cycle.
- Back-to-back: the earliest next `start` is sampled one cycle after `done`, for a throughput of 29 cycles per block.
- All arithmetic is GF(2^8) XOR/xtime, with no carries. `rnd/2` ranges over 1..7.

## Structure
- Package `aes_pkg`:
  - `RCON[1:7]` = 01, 02, 04, 08, 10, 20, 40.
  - FSM state enum.
  - Functions `xtime`, `mix_column` (32-bit), `shift_rows` (128-bit), `rot_word`.
- Sub-module: exactly one existing `subbytes` instance, with its input driven by the sequencer mux. No other sbox copies exist in this block.
- MixColumns, ShiftRows and AddRoundKey are inline combinational logic using package functions.

## Test plan
- **FIPS-197 C.3 vector:** key `000102…1e1f`, plaintext `00112233445566778899aabbccddeeff`. Expect `ciphertext` = `8ea2b7ca516745bfeafc49904b496089` and `done` exactly 27 edges after the `start` edge.
- **Key expansion probe:** key `603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4`. Expect `rk_cur.w0` = `9ba35411` after the first KEY phase (E2).
- **All-zero key and plaintext:** expect `ciphertext` = `dc95c078a2408989ad48a21492842087`.
- **`start` while busy:** pulse `start` at E5 and E20 with different data. Expect the C.3 result, a single `done` pulse, and unchanged latency.
- **`rst` asserted at E12:** expect `busy`=0, `done`=0 and `ciphertext`=0 the next cycle. A new C.3 `start` then completes correctly in 27 edges.
- **Back-to-back:** issue a second `start` in the cycle after `done`. Expect the second result 29 cycles after the first `done`, and the first `ciphertext` held until the second `start` is sampled.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-256 constants, FSM encoding and GF(2^8) helpers for the
// iterative encryption sequencer.
package aes_pkg;

  // Sequencer phases: one KEY + one DATA cycle per round from round 2 on.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_DATA = 2'd2,
    ST_FIN  = 2'd3
  } fsm_e;

  localparam logic [3:0] LAST_RND = 4'd14;

  // Round constants, indexed by rnd/2 for the even (RotWord) key phases.
  localparam logic [7:0] RCON [1:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; byte 0 of the column sits in [31:24].
  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]), mix_column(s[31:0])};
  endfunction

  // Row r rotates left by r columns; byte index = row + 4*col, byte 0 at [127:120].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/subbytes.sv
// 128-bit SubBytes: sixteen parallel AES S-box lookups.
module subbytes (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Each byte lane is an independent table lookup.
  for (genvar i = 0; i < 16; i++) begin : g_lane
    assign dout[8*i +: 8] = SBOX[din[8*i +: 8]];
  end

endmodule

// File: rtl/aes256_enc_sequencer.sv
// Iterative AES-256 encryptor: one shared subbytes instance time-shared
// between on-the-fly key expansion (KEY phase) and the round datapath
// (DATA phase). 27 edges from start sampling to the done cycle.
//
// Host handshake: start is a one-cycle request honoured only in IDLE (key and
// plaintext are captured on that same edge); busy is high until done rises;
// done pulses one cycle with ciphertext valid, and ciphertext holds until the
// next accepted start or rst. start seen while busy or in the done cycle is
// dropped without side effects.
module aes256_enc_sequencer
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] blk_q, blk_d;          // AES state between rounds
  logic [127:0] rk_prev_q, rk_prev_d;  // rk(r-2)
  logic [127:0] rk_cur_q, rk_cur_d;    // rk(r-1); rk(r) once KEY has run
  logic [127:0] ct_q, ct_d;

  logic [127:0] sb_in, sb_out;
  logic [31:0]  key_op, temp;
  logic [2:0]   rcon_idx;
  logic [127:0] rk_new, sr, round_out;

  subbytes u_subbytes (
    .din  (sb_in),
    .dout (sb_out)
  );

  // Shared S-box operand select (by phase only) plus key/round datapaths.
  always_comb begin
    key_op    = rnd_q[0] ? rk_cur_q[31:0] : rot_word(rk_cur_q[31:0]);
    sb_in     = (fsm_q == ST_KEY) ? {key_op, 96'h0} : blk_q;
    // rnd/2 is 1..7 whenever KEY runs; clamp so idle cycles never index RCON[0].
    rcon_idx  = (rnd_q[3:1] == 3'd0) ? 3'd1 : rnd_q[3:1];
    temp      = sb_out[127:96] ^ (rnd_q[0] ? 32'h0 : {RCON[rcon_idx], 24'h0});
    rk_new[127:96] = rk_prev_q[127:96] ^ temp;
    rk_new[95:64]  = rk_prev_q[95:64]  ^ rk_new[127:96];
    rk_new[63:32]  = rk_prev_q[63:32]  ^ rk_new[95:64];
    rk_new[31:0]   = rk_prev_q[31:0]   ^ rk_new[63:32];
    sr        = shift_rows(sb_out);
    round_out = ((rnd_q == LAST_RND) ? sr : mix_columns(sr)) ^ rk_cur_q;
  end

  // Phase sequencing and register next-state.
  always_comb begin
    fsm_d     = fsm_q;
    rnd_d     = rnd_q;
    blk_d     = blk_q;
    rk_prev_d = rk_prev_q;
    rk_cur_d  = rk_cur_q;
    ct_d      = ct_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          blk_d     = plaintext ^ key[255:128];
          rk_prev_d = key[255:128];
          rk_cur_d  = key[127:0];
          rnd_d     = 4'd1;
          ct_d      = '0;
          fsm_d     = ST_DATA;
        end
      end
      ST_KEY: begin
        rk_prev_d = rk_cur_q;
        rk_cur_d  = rk_new;
        fsm_d     = ST_DATA;
      end
      ST_DATA: begin
        blk_d = round_out;
        if (rnd_q == LAST_RND) begin
          ct_d  = round_out;
          fsm_d = ST_FIN;
        end else begin
          rnd_d = rnd_q + 4'd1;
          fsm_d = ST_KEY;
        end
      end
      ST_FIN:  fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= ST_IDLE;
      rnd_q     <= '0;
      blk_q     <= '0;
      rk_prev_q <= '0;
      rk_cur_q  <= '0;
      ct_q      <= '0;
    end else begin
      fsm_q     <= fsm_d;
      rnd_q     <= rnd_d;
      blk_q     <= blk_d;
      rk_prev_q <= rk_prev_d;
      rk_cur_q  <= rk_cur_d;
      ct_q      <= ct_d;
    end
  end

  assign busy       = (fsm_q == ST_KEY) || (fsm_q == ST_DATA);
  assign done       = (fsm_q == ST_FIN);
  assign ciphertext = ct_q;

endmodule
